// File: rtl/keccak_perm_ctrl.sv
// Keccak-f[1600] sequencer: schedules absorb, permute and squeeze on the state register and round datapath.
// Latency: start->first absorb 1 cycle; permute NUM_ROUNDS/ROUNDS_PER_CYCLE cycles; first out_valid the cycle after.
// Backpressure: one lane per in_valid/in_ready or out_valid/out_ready handshake; stalls in place otherwise.
// Optional: define KECCAK_CTRL_PERF_CNT_EN to add the saturating perm_count output.
module keccak_perm_ctrl #(
    parameter int NUM_ROUNDS       = 24,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int RATE_WORDS       = 17,
    localparam int RIW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1,
    localparam int LIW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic           squeeze_stop,
    output logic           state_clr,
    output logic           absorb_en,
    output logic           round_en,
    output logic [RIW-1:0] round_idx,
    output logic [LIW-1:0] lane_idx,
    output logic           busy,
`ifdef KECCAK_CTRL_PERF_CNT_EN
    output logic [31:0]    perm_count,
`endif
    output logic           done
);

    // Reject parameter sets the round counter cannot step through exactly.
    if (ROUNDS_PER_CYCLE < 1 || (NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
    end
    if (RATE_WORDS < 1 || RATE_WORDS > 24) begin : g_bad_rate
        $error("RATE_WORDS must be in 1..24");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ABSORB  = 2'd1,
        PERMUTE = 2'd2,
        SQUEEZE = 2'd3
    } state_t;

    state_t state, state_n;
    logic   final_q;
    logic   lane_last;
    logic   round_last;

    assign lane_last  = (lane_idx == LIW'(RATE_WORDS - 1));
    assign round_last = (round_idx == RIW'(NUM_ROUNDS - ROUNDS_PER_CYCLE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode plus all control outputs (Mealy ones gated by live inputs).
    always_comb begin
        state_n   = state;
        state_clr = 1'b0;
        absorb_en = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        round_en  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_clr = 1'b1;
                    state_n   = ABSORB;
                end
            end
            ABSORB: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    absorb_en = 1'b1;
                    // A short final block leaves unwritten lanes untouched (XOR with zero).
                    if (in_last || lane_last) state_n = PERMUTE;
                end
            end
            PERMUTE: begin
                round_en = 1'b1;
                if (round_last) state_n = final_q ? SQUEEZE : ABSORB;
            end
            SQUEEZE: begin
                out_valid = 1'b1;
                // Stop wins over the refill permutation so the consumer can always end cleanly.
                if (squeeze_stop) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (out_ready && lane_last) begin
                    state_n = PERMUTE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Lane/round counters and the message-complete flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_idx  <= '0;
            round_idx <= '0;
            final_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lane_idx  <= '0;
                        round_idx <= '0;
                        final_q   <= 1'b0;
                    end
                end
                ABSORB: begin
                    if (in_valid) begin
                        lane_idx <= lane_idx + LIW'(1);
                        if (in_last)        final_q <= 1'b1;
                        else if (lane_last) final_q <= 1'b0;
                    end
                end
                PERMUTE: begin
                    if (round_last) begin
                        round_idx <= '0;
                        lane_idx  <= '0;
                    end else begin
                        round_idx <= round_idx + RIW'(ROUNDS_PER_CYCLE);
                    end
                end
                SQUEEZE: begin
                    // A lane taken in the same cycle as squeeze_stop still counts as consumed.
                    if (out_ready) lane_idx <= lane_idx + LIW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef KECCAK_CTRL_PERF_CNT_EN
    // Completed-permutation counter, cleared per hash and held at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_count <= '0;
        end else if (state == IDLE && start) begin
            perm_count <= '0;
        end else if (state == PERMUTE && round_last && perm_count != 32'hFFFF_FFFF) begin
            perm_count <= perm_count + 32'd1;
        end
    end
`endif

endmodule
